// File: rtl/opsg_pkg.sv
// Shared definitions for the opsg host-side register writer: register
// indices, FSM state encoding, the command record and its byte encoders.
`timescale 1ns/1ps
package opsg_pkg;

  // PSG register indices, {channel, is_volume}
  localparam logic [2:0] REG_FREQ1 = 3'b000;
  localparam logic [2:0] REG_VOL1  = 3'b001;
  localparam logic [2:0] REG_FREQ2 = 3'b010;
  localparam logic [2:0] REG_VOL2  = 3'b011;
  localparam logic [2:0] REG_FREQ3 = 3'b100;
  localparam logic [2:0] REG_VOL3  = 3'b101;
  localparam logic [2:0] REG_CTRL4 = 3'b110;
  localparam logic [2:0] REG_VOL4  = 3'b111;

  // Attenuation end points: 0xF silences a channel, 0x0 is loudest
  localparam logic [3:0] ATT_OFF = 4'hF;
  localparam logic [3:0] ATT_MAX = 4'h0;

  // Writer FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LATCH_LO  = 3'd1;
  localparam logic [2:0] ST_LATCH_GAP = 3'd2;
  localparam logic [2:0] ST_DATA_LO   = 3'd3;
  localparam logic [2:0] ST_DATA_GAP  = 3'd4;

  localparam int CMD_W = 13;

  // One queued command, laid out as {vol, chan, value}
  typedef struct packed {
    logic       vol;
    logic [1:0] chan;
    logic [9:0] value;
  } opsg_cmd_t;

  // Register index addressed by a command
  function automatic logic [2:0] cmd_reg(input opsg_cmd_t c);
    return {c.chan, c.vol};
  endfunction

  // Channel 3 without the volume flag is the noise control register
  function automatic logic is_noise(input opsg_cmd_t c);
    return !c.vol && (c.chan == 2'd3);
  endfunction

  // Tone commands are the only two-byte writes
  function automatic logic is_tone(input opsg_cmd_t c);
    return !c.vol && (c.chan != 2'd3);
  endfunction

  // Value with the bits the target register ignores forced to zero
  function automatic logic [9:0] used_bits(input opsg_cmd_t c);
    logic [9:0] v;
    if (is_tone(c))  v = c.value;
    else if (c.vol)  v = {6'd0, c.value[3:0]};
    else             v = {7'd0, c.value[2:0]};
    return v;
  endfunction

  // First (latch) byte of a command
  function automatic logic [7:0] latch_byte(input opsg_cmd_t c);
    logic [7:0] b;
    if (is_noise(c)) b = {1'b1, REG_CTRL4, 1'b0, c.value[2:0]};
    else             b = {1'b1, cmd_reg(c), c.value[3:0]};
    return b;
  endfunction

  // Second byte of a tone command: upper six period bits
  function automatic logic [7:0] data_byte(input opsg_cmd_t c);
    return {2'b00, c.value[9:4]};
  endfunction

endpackage

// File: rtl/opsg_cmd_fifo.sv
// Single-clock command FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
`timescale 1ns/1ps
module opsg_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem[rd_ptr_q[AW-1:0]];

  // Advance pointers on accepted push/pop; callers gate with full/empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port
  // NOTE: entries are not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/opsg_writer.sv
// Host-side register writer for the opsg sound generator. Commands are
// queued, checked against a shadow of the last value written to each
// register, then serialised into one or two strobed bytes on n_wr/data.
`timescale 1ns/1ps
module opsg_writer
  import opsg_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int WR_LOW         = 1,
  parameter int WR_GAP         = 1,
  parameter int SKIP_REDUNDANT = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_vol,
  input  logic [1:0] cmd_chan,
  input  logic [9:0] cmd_value,
  output logic       n_wr,
  output logic [7:0] data,
  output logic       busy
);

  localparam int CNT_MAX = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(WR_LOW - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(WR_GAP - 1);

  opsg_cmd_t push_cmd;
  opsg_cmd_t fifo_head;
  logic      fifo_full, fifo_empty;
  logic      fifo_push, fifo_pop;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  opsg_cmd_t        cur_q, cur_d;
  logic             n_wr_q, n_wr_d;
  logic [7:0]       data_q, data_d;

  logic [7:0]       shadow_vld_q, shadow_vld_d;
  logic [7:0][9:0]  shadow_val_q, shadow_val_d;
  logic             shadow_wr;
  logic             head_redundant;
  logic             fetch;

  // Ready depends only on registered FIFO state, so a pop in the same
  // cycle as a full FIFO does not admit a push until the next cycle.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign push_cmd  = {cmd_vol, cmd_chan, cmd_value};

  opsg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (fifo_push),
    .wdata (push_cmd),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_redundant = (SKIP_REDUNDANT != 0) &&
                          shadow_vld_q[cmd_reg(fifo_head)] &&
                          (shadow_val_q[cmd_reg(fifo_head)] == used_bits(fifo_head));

  assign n_wr = n_wr_q;
  assign data = data_q;
  assign busy = !fifo_empty || (state_q != ST_IDLE);

  // Writer FSM: strobe timing, byte selection and FIFO fetch
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    n_wr_d    = 1'b1;
    data_d    = data_q;
    fifo_pop  = 1'b0;
    shadow_wr = 1'b0;
    fetch     = 1'b0;

    case (state_q)
      ST_IDLE: fetch = 1'b1;

      ST_LATCH_LO: begin
        n_wr_d    = 1'b0;
        data_d    = latch_byte(cur_q);
        shadow_wr = 1'b1;
        if (cnt_q == LOW_LAST) begin
          cnt_d   = '0;
          state_d = ST_LATCH_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_LATCH_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (is_tone(cur_q)) state_d = ST_DATA_LO;
          else                fetch   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA_LO: begin
        n_wr_d = 1'b0;
        data_d = data_byte(cur_q);
        if (cnt_q == LOW_LAST) begin
          cnt_d   = '0;
          state_d = ST_DATA_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          fetch = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Fetching on the last gap cycle keeps back-to-back commands at
    // minimum pitch; a redundant head is consumed and leaves us in IDLE.
    if (fetch) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        if (!head_redundant) begin
          state_d = ST_LATCH_LO;
          cur_d   = fifo_head;
        end
      end
    end
  end

  // Shadow of the last value issued to each register, keyed by reg index
  always_comb begin
    shadow_vld_d = shadow_vld_q;
    shadow_val_d = shadow_val_q;
    if (shadow_wr) begin
      shadow_vld_d[cmd_reg(cur_q)] = 1'b1;
      shadow_val_d[cmd_reg(cur_q)] = used_bits(cur_q);
    end
  end

  // State, output and shadow registers; reset idles the bus immediately
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      n_wr_q       <= 1'b1;
      data_q       <= 8'h00;
      shadow_vld_q <= '0;
      shadow_val_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      n_wr_q       <= n_wr_d;
      data_q       <= data_d;
      shadow_vld_q <= shadow_vld_d;
      shadow_val_q <= shadow_val_d;
    end
  end

endmodule

// File: doc/opsg_writer.md
# opsg_writer

Host-side register writer for the `opsg` sound generator. It accepts high-level commands from a CPU or sequencer through a valid/ready handshake: tone period, attenuation, or noise control for a given channel. It buffers them in a small FIFO and serialises each one into the PSG byte protocol on `n_wr`/`data`. It sits between the system bus or music player and the `opsg` instance, on the same clock.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `WR_LOW`, 1: cycles `n_wr` is held low per byte; ≥1.
- `WR_GAP`, 1: cycles `n_wr` is held high between bytes; ≥1.
- `SKIP_REDUNDANT`, 1: when 1, drop commands whose value equals the shadowed register value.
- `clk`  in  1  system clock; same clock as `opsg`.
- `n_rst`  in  1  reset; one clock, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_vol`  in  1  1 = attenuation command, 0 = tone/noise-control command.
- `cmd_chan`  in  2  channel 0–3; channel 3 with `cmd_vol`=0 is noise control.
- `cmd_value`  in  10  tone period [9:0], attenuation [3:0], or noise ctrl [2:0]; unused bits ignored.
- `n_wr`  out  1  active-low byte strobe to `opsg`.
- `data`  out  8  byte to `opsg`.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Push happens when `cmd_valid & cmd_ready`. The FIFO stores `{cmd_vol, cmd_chan, cmd_value}`.
- Register index `reg = {cmd_chan, cmd_vol}`.
- Byte encoding:
  - Tone, channel 0–2: two bytes. Latch byte `{1, reg, value[3:0]}`, then data byte `{00, value[9:4]}`.
  - Attenuation: one byte, `{1, reg, value[3:0]}`.
  - Noise control: one byte, `{1, 110, 0, value[2:0]}`.
- FSM states: IDLE → LATCH_LO → LATCH_GAP → (two-byte command) DATA_LO → DATA_GAP → IDLE; one-byte commands go LATCH_GAP → IDLE.
  - IDLE pops when the FIFO is non-empty.
  - `*_LO` holds `n_wr`=0 for `WR_LOW` cycles.
  - `*_GAP` holds `n_wr`=1 for `WR_GAP` cycles.
- Shadow: 8 entries of 10 bits, each with a valid bit, indexed by `reg`. The entry is updated when the command's first byte is issued.
  - With `SKIP_REDUNDANT`=1, a popped command whose shadow entry is valid and equal (compared on the used bits only) is discarded.
  - A discarded command returns to IDLE in 1 cycle with no strobe.
- `data` keeps the last driven byte while `n_wr` is high.
- FIFO full: `cmd_ready`=0 and the offered command is not accepted.
- Simultaneous push and pop when the FIFO is full is allowed: the pop frees a slot, but `cmd_ready` is computed from registered state only, so a push is not accepted that cycle.

## Timing
- Reset values: `n_wr`=1, `data`=0x00, `cmd_ready`=1, `busy`=0, FIFO empty, FSM IDLE, all shadow entries invalid.
- `n_wr` and `data` are registered outputs and change only on a `clk` rising edge, except during reset.
- Latency: a command accepted at edge E is popped at edge E+1. `n_wr` falls and the first byte appears at edge E+2.
- `data` is stable for the whole `n_wr`-low window.
- Back-to-back commands: the next latch byte follows the previous `*_GAP` with no extra IDLE cycle when the FIFO is non-empty (pop happens on the last GAP cycle).
- Minimum pitch at defaults:
  - one-byte command: 2 cycles;
  - tone command: 4 cycles.
- Reset asserted mid-command:
  - `n_wr` goes high and `data` goes to 0 immediately;
  - the in-flight byte pair is abandoned and the FIFO is flushed;
  - shadows are invalidated, so the next write is always issued.

## Structure
- Shared package `opsg_pkg` holds:
  - register index constants (`REG_FREQ1`=000 … `REG_VOL4`=111);
  - the FSM state encoding;
  - attenuation constants `ATT_OFF`=4'hF, `ATT_MAX`=4'h0.
- Sub-module `opsg_cmd_fifo`: synchronous single-clock FIFO, `FIFO_DEPTH`×13 bits, with `full`/`empty` flags and pointers one bit wider than the address.
- Top level contains the FSM, the byte encoder, the shadow, and the counters.

## Test plan
- Tone, chan 0, value 0x3FE → `data`=0x8E with `n_wr` low for 1 cycle, gap, then 0x3F with `n_wr` low for 1 cycle; `busy` is 0 afterwards.
- Attenuation, chan 2, value 5 → single strobe with `data`=0xD5; a repeat of the same command with `SKIP_REDUNDANT`=1 produces no strobe.
- Noise control, value 3'b011 → single strobe with `data`=0xE3. A following tone on chan 3 is encoded as noise control and is not emitted as two bytes.
- Five back-to-back pushes with `FIFO_DEPTH`=4 while the FSM is stalled → `cmd_ready` drops after the fourth accepted push. All accepted commands emerge in order with no byte lost.
- Reset pulsed during DATA_LO of a tone command → `n_wr`=1 and `data`=0 asynchronously. After release the FIFO is empty and `busy`=0, and re-issuing the same tone produces both bytes.
- Bench model: feed `n_wr`/`data` into `opsg` and check that its `freq*`/`vol*`/`ctrl4` registers match the command stream.
